// File: rtl/logic_unit_pkg.sv
// Shared encodings for the serial logic unit: operation selects and FSM states.
package logic_unit_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/chunk_logic.sv
// Combinational bitwise operation on one CHUNK-wide slice of the operands.
module chunk_logic
  import logic_unit_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic [1:0]       op,
  output logic [CHUNK-1:0] r
);

  always_comb begin
    r = '0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      default: r = '0;
    endcase
  end

endmodule

// File: rtl/serial_logic_unit.sv
// Bit-serial logic unit: applies AND/OR/XOR/NOR to latched operands one chunk
// per cycle, LSB chunk first, and holds the result until the consumer takes it.
module serial_logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] R,
  output logic             zero
);

  localparam int K  = WIDTH / CHUNK;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res;
  logic [1:0]       op_q;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] chunk_r;

  assign chunk_a = a_q[cnt*CHUNK +: CHUNK];
  assign chunk_b = b_q[cnt*CHUNK +: CHUNK];

  chunk_logic #(.CHUNK(CHUNK)) u_chunk (
    .a  (chunk_a),
    .b  (chunk_b),
    .op (op_q),
    .r  (chunk_r)
  );

  // Counter wraps to 0 on the last chunk so it never exceeds K-1, even when K
  // is not a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      res       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q      <= A;
            b_q      <= B;
            op_q     <= op;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          res[cnt*CHUNK +: CHUNK] <= chunk_r;
          if (cnt == LAST) begin
            cnt       <= '0;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign R    = res;
  assign zero = ~|res;

endmodule

// File: tb/tb_serial_logic_unit.sv
// Directed bench for serial_logic_unit: vector table for the default 32/8
// configuration plus hand-written sequences and a single-chunk 16/16 instance.
module tb_serial_logic_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'b00;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] R;
  logic        zero;

  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [1:0]  s_op = 2'b00;
  logic [15:0] s_A = '0;
  logic [15:0] s_B = '0;
  logic        s_out_valid;
  logic        s_out_ready = 1'b0;
  logic [15:0] s_R;
  logic        s_zero;

  int checks = 0;
  int errors = 0;

  serial_logic_unit #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .R(R), .zero(zero)
  );

  serial_logic_unit #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .op(s_op), .A(s_A), .B(s_B), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .R(s_R), .zero(s_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_r;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one operation and let the accepting edge happen.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
    @(negedge clk);
    A = a; B = b; op = o; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDone(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic releaseResult(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({name, ".rel_in_ready"}, {31'd0, in_ready}, 32'd1);
    checkOutput({name, ".rel_out_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int lat;

    vecs[0] = '{"xor_req29", 2'b10, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0};
    vecs[1] = '{"xor_same",  2'b10, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1};
    vecs[2] = '{"and_alt",   2'b00, 32'hAAAAAAAA, 32'h55555555, 32'h00000000, 1'b1};
    vecs[3] = '{"or_alt",    2'b01, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 1'b0};
    vecs[4] = '{"nor_alt",   2'b11, 32'hAAAAAAAA, 32'h55555555, 32'h00000000, 1'b1};
    vecs[5] = '{"and_edges", 2'b00, 32'hFFFFFFFF, 32'h80000001, 32'h80000001, 1'b0};
    vecs[6] = '{"nor_mix",   2'b11, 32'h0000FFFF, 32'h00FF0000, 32'hFF000000, 1'b0};
    vecs[7] = '{"or_zero",   2'b01, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst.in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst.out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst.R", R, 32'd0);
    checkOutput("rst.zero", {31'd0, zero}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].op);
      checkOutput({vecs[i].name, ".busy"}, {31'd0, in_ready}, 32'd0);
      waitDone(lat);
      checkOutput({vecs[i].name, ".latency"}, lat, 32'd4);
      checkOutput({vecs[i].name, ".R"}, R, vecs[i].exp_r);
      checkOutput({vecs[i].name, ".zero"}, {31'd0, zero}, {31'd0, vecs[i].exp_zero});
      releaseResult(vecs[i].name);
    end

    // Result held while the consumer stalls.
    applyStimulus(32'h12345678, 32'h12345678, 2'b10);
    waitDone(lat);
    checkOutput("hold.latency", lat, 32'd4);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("hold.R", R, 32'd0);
      checkOutput("hold.zero", {31'd0, zero}, 32'd1);
      checkOutput("hold.out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("hold.in_ready", {31'd0, in_ready}, 32'd0);
    end
    releaseResult("hold");

    // Inputs scrambled during RUN, including stray out_ready, must not matter.
    applyStimulus(32'hFFFFFFFF, 32'h00000000, 2'b01);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      A = $urandom; B = $urandom; op = 2'(lat); in_valid = ~in_valid; out_ready = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checkOutput("scramble.latency", lat, 32'd4);
    checkOutput("scramble.R", R, 32'hFFFFFFFF);
    checkOutput("scramble.zero", {31'd0, zero}, 32'd0);
    releaseResult("scramble");

    // Reset after two RUN cycles aborts with no out_valid pulse.
    applyStimulus(32'hFFFF0000, 32'h0F0F0F0F, 2'b10);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("abort.in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("abort.out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("abort.R", R, 32'd0);
    checkOutput("abort.zero", {31'd0, zero}, 32'd1);
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) lat++;
    end
    checkOutput("abort.no_pulse", lat, 32'd0);

    // Single-chunk configuration completes one edge after acceptance.
    @(negedge clk);
    s_A = 16'h00FF; s_B = 16'h0FF0; s_op = 2'b00; s_in_valid = 1'b1;
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    checkOutput("k1.in_ready", {31'd0, s_in_ready}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("k1.out_valid", {31'd0, s_out_valid}, 32'd1);
    checkOutput("k1.R", {16'd0, s_R}, 32'h000000F0);
    checkOutput("k1.zero", {31'd0, s_zero}, 32'd0);
    @(negedge clk);
    s_out_ready = 1'b1;
    @(posedge clk);
    #1;
    s_out_ready = 1'b0;
    checkOutput("k1.rel_in_ready", {31'd0, s_in_ready}, 32'd1);
    checkOutput("k1.rel_out_valid", {31'd0, s_out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
